// File: rtl/adcv_sample_averager_if.sv
// Result channel of the sample averager: one registered mean/min/max word
// moved with a ready/valid handshake.
interface adcv_sample_averager_if #(
  parameter int unsigned SAMPLE_BITS = 8
);
  logic [SAMPLE_BITS-1:0] avg_out;
  logic [SAMPLE_BITS-1:0] min_out;
  logic [SAMPLE_BITS-1:0] max_out;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output avg_out,
    output min_out,
    output max_out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  avg_out,
    input  min_out,
    input  max_out,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/adcv_sample_averager.sv
// Windowed averager for the ramp-ADC code stream: sums 2^LOG2_N valid codes and
// emits a round-half-up mean plus window min/max on a single-entry result register.
module adcv_sample_averager #(
  parameter int unsigned SAMPLE_BITS = 8,
  parameter int unsigned LOG2_N      = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [SAMPLE_BITS-1:0] sample_in,
  input  logic                   sample_valid,
  output logic                   overrun,
  output logic [LOG2_N-1:0]      window_fill,
  adcv_sample_averager_if.master res
);

  localparam int unsigned ACC_W  = SAMPLE_BITS + LOG2_N;
  localparam int unsigned N      = 1 << LOG2_N;
  localparam int unsigned HALF   = 1 << (LOG2_N - 1);
  localparam int unsigned MEAN_W = SAMPLE_BITS + 1;

  logic [ACC_W-1:0]       acc_q,     acc_d;
  logic [LOG2_N-1:0]      count_q,   count_d;
  logic [SAMPLE_BITS-1:0] run_min_q, run_min_d;
  logic [SAMPLE_BITS-1:0] run_max_q, run_max_d;
  logic [SAMPLE_BITS-1:0] avg_q,     avg_d;
  logic [SAMPLE_BITS-1:0] min_q,     min_d;
  logic [SAMPLE_BITS-1:0] max_q,     max_d;
  logic                   valid_q,   valid_d;
  logic                   overrun_q, overrun_d;

  logic                   accept_c;
  logic                   close_c;
  logic                   load_c;
  logic [ACC_W-1:0]       sum_c;
  logic [ACC_W:0]         rnd_c;
  logic [MEAN_W-1:0]      mean_c;
  logic [SAMPLE_BITS-1:0] avg_c;
  logic [SAMPLE_BITS-1:0] new_min_c;
  logic [SAMPLE_BITS-1:0] new_max_c;

  // Running sum including the current code, rounded mean with saturation guard
  always_comb begin
    accept_c  = sample_valid && !clear;
    close_c   = accept_c && (count_q == LOG2_N'(N - 1));
    load_c    = close_c && (!valid_q || res.out_ready);
    sum_c     = acc_q + ACC_W'(sample_in);
    rnd_c     = {1'b0, sum_c} + (ACC_W + 1)'(HALF);
    mean_c    = MEAN_W'(rnd_c >> LOG2_N);
    avg_c     = mean_c[MEAN_W-1] ? '1 : mean_c[SAMPLE_BITS-1:0];
    new_min_c = (sample_in < run_min_q) ? sample_in : run_min_q;
    new_max_c = (sample_in > run_max_q) ? sample_in : run_max_q;
  end

  // Next-state: window accumulation, result register load and overrun tracking
  always_comb begin
    acc_d     = acc_q;
    count_d   = count_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    avg_d     = avg_q;
    min_d     = min_q;
    max_d     = max_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (valid_q && res.out_ready) begin
      valid_d = 1'b0;
    end

    if (clear) begin
      // Restart the window; the pending result is left deliverable
      acc_d     = '0;
      count_d   = '0;
      run_min_d = '1;
      run_max_d = '0;
      overrun_d = 1'b0;
    end else if (close_c) begin
      acc_d     = '0;
      count_d   = '0;
      run_min_d = '1;
      run_max_d = '0;
      if (load_c) begin
        avg_d   = avg_c;
        min_d   = new_min_c;
        max_d   = new_max_c;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept_c) begin
      acc_d     = sum_c;
      count_d   = count_q + LOG2_N'(1);
      run_min_d = new_min_c;
      run_max_d = new_max_c;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      count_q   <= '0;
      run_min_q <= '1;
      run_max_q <= '0;
      avg_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      count_q   <= count_d;
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      avg_q     <= avg_d;
      min_q     <= min_d;
      max_q     <= max_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign res.avg_out   = avg_q;
  assign res.min_out   = min_q;
  assign res.max_out   = max_q;
  assign res.out_valid = valid_q;
  assign overrun       = overrun_q;
  assign window_fill   = count_q;

endmodule

// File: tb/tb_adcv_sample_averager.sv
// Scoreboard bench for adcv_sample_averager: a behavioural window model queues
// expected results, which are popped and compared on every output transfer.
module tb_adcv_sample_averager;

  localparam int unsigned SB   = 8;
  localparam int unsigned L2N  = 4;
  localparam int          NWIN = 16;

  typedef struct packed {
    logic [SB-1:0] avg;
    logic [SB-1:0] mn;
    logic [SB-1:0] mx;
  } result_t;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           clear = 1'b0;
  logic [SB-1:0]  sample_in = '0;
  logic           sample_valid = 1'b0;
  logic           overrun;
  logic [L2N-1:0] window_fill;

  adcv_sample_averager_if #(.SAMPLE_BITS(SB)) res_if ();

  adcv_sample_averager #(.SAMPLE_BITS(SB), .LOG2_N(L2N)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (clear),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .window_fill  (window_fill),
    .res          (res_if)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  result_t sbq[$];
  int m_acc, m_count, m_min, m_max;
  bit m_valid, m_ovr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input bit full);
    m_acc = 0; m_count = 0; m_min = 255; m_max = 0; m_ovr = 0;
    if (full) begin
      m_valid = 0;
      sbq.delete();
    end
  endtask

  // One cycle: check state left by the previous edge, drive inputs, advance model
  task automatic step(input logic v, input logic [SB-1:0] s, input logic r, input logic c);
    result_t e;
    int sum, mn, mx, avg;
    bit load;
    @(negedge clock);
    chk("out_valid", 32'(res_if.out_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("window_fill", 32'(window_fill), 32'(m_count));
    sample_valid     = v;
    sample_in        = s;
    res_if.out_ready = r;
    clear            = c;
    if (m_valid && r) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        chk("avg_out", 32'(res_if.avg_out), 32'(e.avg));
        chk("min_out", 32'(res_if.min_out), 32'(e.mn));
        chk("max_out", 32'(res_if.max_out), 32'(e.mx));
      end
    end
    load = 0;
    if (c) begin
      model_reset(0);
    end else if (v) begin
      sum = m_acc + int'(s);
      mn  = (int'(s) < m_min) ? int'(s) : m_min;
      mx  = (int'(s) > m_max) ? int'(s) : m_max;
      if (m_count == NWIN - 1) begin
        avg = (sum + NWIN / 2) / NWIN;
        if (avg > 255) avg = 255;
        e.avg = SB'(avg);
        e.mn  = SB'(mn);
        e.mx  = SB'(mx);
        if (!m_valid || r) begin
          load = 1;
          sbq.push_back(e);
        end else begin
          m_ovr = 1;
        end
        m_acc = 0; m_count = 0; m_min = 255; m_max = 0;
      end else begin
        m_acc = sum; m_count++; m_min = mn; m_max = mx;
      end
    end
    if (load) m_valid = 1;
    else if (m_valid && r) m_valid = 0;
  endtask

  task automatic window_const(input logic [SB-1:0] s, input logic r);
    for (int i = 0; i < NWIN; i++) step(1'b1, s, r, 1'b0);
  endtask

  // Direct check of the presented result against hand-derived constants
  task automatic expect_out(input string tag, input int a, input int mn, input int mx);
    chk({tag, "_valid"}, 32'(res_if.out_valid), 32'd1);
    chk({tag, "_avg"}, 32'(res_if.avg_out), 32'(a));
    chk({tag, "_min"}, 32'(res_if.min_out), 32'(mn));
    chk({tag, "_max"}, 32'(res_if.max_out), 32'(mx));
  endtask

  initial begin
    res_if.out_ready = 1'b0;
    model_reset(1);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(res_if.out_valid), 32'd0);
    chk("rst_avg", 32'(res_if.avg_out), 32'd0);
    chk("rst_max", 32'(res_if.max_out), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_fill", 32'(window_fill), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Constant window, consumer ready
    window_const(8'd100, 1'b1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    expect_out("t1", 100, 100, 100);
    step(1'b0, 8'd0, 1'b1, 1'b0);

    // Ramp 0..15
    for (int i = 0; i < NWIN; i++) step(1'b1, SB'(i), 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    expect_out("t2", 8, 0, 15);
    chk("t2_fill", 32'(window_fill), 32'd0);

    // Rounding boundaries
    for (int i = 0; i < NWIN - 1; i++) step(1'b1, 8'd0, 1'b1, 1'b0);
    step(1'b1, 8'd8, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    expect_out("t3_up", 1, 0, 8);
    for (int i = 0; i < NWIN - 1; i++) step(1'b1, 8'd0, 1'b1, 1'b0);
    step(1'b1, 8'd7, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    expect_out("t3_down", 0, 0, 7);
    window_const(8'd255, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    expect_out("t3_full", 255, 255, 255);
    step(1'b0, 8'd0, 1'b1, 1'b0);

    // Backpressure: second window dropped, first held
    window_const(8'd10, 1'b0);
    window_const(8'd20, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    expect_out("t4_hold", 10, 10, 10);
    chk("t4_overrun", 32'(overrun), 32'd1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("t4_cleared", 32'(overrun), 32'd0);

    // Transfer and load on the same edge
    window_const(8'd30, 1'b0);
    for (int i = 0; i < NWIN - 1; i++) step(1'b1, 8'd40, 1'b0, 1'b0);
    step(1'b1, 8'd40, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    expect_out("t5_new", 40, 40, 40);
    chk("t5_overrun", 32'(overrun), 32'd0);
    step(1'b0, 8'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-window
    for (int i = 0; i < 7; i++) step(1'b1, 8'd200, 1'b1, 1'b0);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_fill", 32'(window_fill), 32'd0);
    chk("t6_rst_valid", 32'(res_if.out_valid), 32'd0);
    sample_valid = 1'b0;
    model_reset(1);
    #4 reset_n = 1'b1;
    window_const(8'd50, 1'b1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    expect_out("t6_rst", 50, 50, 50);

    // Clear wins over a concurrent sample
    for (int i = 0; i < 5; i++) step(1'b1, 8'd90, 1'b1, 1'b0);
    step(1'b1, 8'd250, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t6_clr_fill", 32'(window_fill), 32'd0);
    for (int i = 0; i < NWIN; i++) step(1'b1, SB'(60 + i), 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    expect_out("t6_clr", 68, 60, 75);

    repeat (3) step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
